// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic {BLANKING, SHOWING} scan_state_t;

   typedef logic [3:0] hex_t;

   typedef struct packed {
      hex_t val;
      logic on;
   } digit_t;

endpackage

// File: rtl/seg_scan_ctrl_seven_seg.sv
// Hex to 7-segment decoder, active-low segments ordered g..a.
module seven_seg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      unique case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with double-buffered digits
// and frame-aligned commit.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 50000,
   parameter int BLANK      = 1000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
   input  logic [3:0]                    wr_data,
   input  logic                          wr_on,
   input  logic                          commit,
   output logic                          commit_ack,
   output logic                          pending,
   output logic [6:0]                    led,
   output logic [NUM_DIGITS-1:0]         an,
   output logic                          frame_start
);

   localparam int AW = $clog2(NUM_DIGITS);
   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0]          cnt, cnt_nxt;
   logic [AW-1:0]          idx, idx_nxt;
   scan_state_t            state, state_nxt;
   digit_t                 shadow [NUM_DIGITS];
   digit_t                 active [NUM_DIGITS];
   digit_t                 cur;
   logic [6:0]             dec_seg;
   logic [6:0]             led_nxt;
   logic [NUM_DIGITS-1:0]  an_nxt;
   logic                   slot_end, boundary;

   assign cur = active[idx];

   seven_seg u_dec (
      .hex (cur.val),
      .seg (dec_seg)
   );

   always_comb begin
      slot_end  = (cnt == CW'(DIV - 1));
      boundary  = slot_end && (idx == AW'(NUM_DIGITS - 1));
      cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
      idx_nxt   = idx;
      if (slot_end)
         idx_nxt = (idx == AW'(NUM_DIGITS - 1)) ? '0 : idx + AW'(1);
      // state tracks the registered cnt, so derive it from the next count
      state_nxt = (32'(cnt_nxt) < 32'(BLANK)) ? BLANKING : SHOWING;
      led_nxt   = SEG_OFF;
      an_nxt    = '1;
      if (state == SHOWING && cur.on) begin
         led_nxt = dec_seg;
         an_nxt  = ~(NUM_DIGITS'(1) << idx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         idx         <= '0;
         state       <= BLANKING;
         pending     <= 1'b0;
         commit_ack  <= 1'b0;
         led         <= SEG_OFF;
         an          <= '1;
         frame_start <= 1'b0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         state       <= state_nxt;
         led         <= led_nxt;
         an          <= an_nxt;
         frame_start <= (idx == '0) && (cnt == '0);
         if (boundary && pending) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
               active[i] <= shadow[i];
            pending    <= 1'b0;
            commit_ack <= 1'b1;
         end else begin
            commit_ack <= 1'b0;
            if (commit)
               pending <= 1'b1;
         end
         if (wr_en && (32'(wr_addr) < 32'(NUM_DIGITS)))
            shadow[wr_addr] <= '{val: wr_data, on: wr_on};
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scenario bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = N * DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1, wr_en = 1'b0, wr_on = 1'b0, commit = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic       commit_ack, pending, frame_start;
   logic [6:0] led;
   logic [3:0] an;

   int ncmp = 0;
   int nfail = 0;

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // reference model: frame position plus the two digit buffers
   logic [3:0] m_sh_val [N];
   logic       m_sh_on  [N];
   logic [3:0] m_act_val[N];
   logic       m_act_on [N];
   logic       m_pend;
   int         mpos;
   int         outpos;
   logic [6:0] e_led;
   logic [3:0] e_an;
   logic       e_fs, e_pend, e_ack;

   seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK(BLANK)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_on       (wr_on),
      .commit      (commit),
      .commit_ack  (commit_ack),
      .pending     (pending),
      .led         (led),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic string obs();
      return $sformatf("got led=%h an=%b fs=%b pend=%b ack=%b / exp led=%h an=%b fs=%b pend=%b ack=%b",
                       led, an, frame_start, pending, commit_ack,
                       e_led, e_an, e_fs, e_pend, e_ack);
   endfunction

   task automatic tick(input logic r, input logic we, input logic [1:0] wa,
                       input logic [3:0] wd, input logic won, input logic cm);
      int slot, c;
      reset = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_on = won; commit = cm;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < N; i++) begin
            m_sh_val[i] = '0; m_sh_on[i] = 1'b0; m_act_val[i] = '0; m_act_on[i] = 1'b0;
         end
         m_pend = 1'b0; mpos = 0; outpos = -1;
         e_led = 7'h7F; e_an = 4'hF; e_fs = 1'b0; e_pend = 1'b0; e_ack = 1'b0;
      end else begin
         slot  = mpos / DIV;
         c     = mpos % DIV;
         e_led = 7'h7F;
         e_an  = 4'hF;
         if (c >= BLANK && m_act_on[slot]) begin
            e_an[slot] = 1'b0;
            e_led      = dec[m_act_val[slot]];
         end
         e_fs  = (mpos == 0);
         e_ack = (mpos == FRAME - 1) && m_pend;
         if (e_ack) begin
            for (int i = 0; i < N; i++) begin
               m_act_val[i] = m_sh_val[i]; m_act_on[i] = m_sh_on[i];
            end
            m_pend = 1'b0;
         end else if (cm) begin
            m_pend = 1'b1;
         end
         if (we) begin
            m_sh_val[wa] = wd; m_sh_on[wa] = won;
         end
         e_pend = m_pend;
         outpos = mpos;
         mpos   = (mpos + 1) % FRAME;
      end
      #1;
   endtask

   task automatic test_reset();
      int fs_cnt = 0;
      repeat (3) begin
         tick(1, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {7'h7F, 4'hF, 3'b000}) begin
            nfail++; $display("FAIL reset_hold %s", obs());
         end
      end
      repeat (40) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL idle_model %s", obs());
         end
         ncmp++;
         if (an !== 4'hF || led !== 7'h7F || pending !== 1'b0) begin
            nfail++; $display("FAIL idle_dark an=%b led=%h pend=%b, want an=1111 led=7f pend=0", an, led, pending);
         end
         if (frame_start === 1'b1) fs_cnt++;
      end
      ncmp++;
      if (fs_cnt !== 2) begin
         nfail++; $display("FAIL idle_frame_count got %0d want 2", fs_cnt);
      end
   endtask

   task automatic test_commit();
      int acks = 0;
      bit got = 0;
      for (int i = 0; i < N; i++) tick(0, 1, 2'(i), 4'(i + 1), 1, 0);
      tick(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 80 && !got; k++) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL commit_wait %s", obs());
         end
         if (commit_ack === 1'b1) begin got = 1; acks++; end
         else begin
            ncmp++;
            if (pending !== 1'b1) begin nfail++; $display("FAIL commit_pending got %b want 1", pending); end
         end
      end
      ncmp++;
      if (!got) begin nfail++; $display("FAIL commit_ack_timeout got none want 1"); end
      repeat (FRAME) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL commit_frame %s", obs());
         end
         if (commit_ack === 1'b1) acks++;
         if (outpos == 5 || outpos == 13) begin
            ncmp++;
            if ((outpos == 5 && {an, led} !== {4'b1110, 7'b1111001}) ||
                (outpos == 13 && {an, led} !== {4'b1101, 7'b0100100})) begin
               nfail++; $display("FAIL commit_digits pos=%0d an=%b led=%b", outpos, an, led);
            end
         end
      end
      ncmp++;
      if (acks !== 1) begin nfail++; $display("FAIL commit_ack_count got %0d want 1", acks); end
   endtask

   task automatic test_no_commit();
      bit got = 0;
      tick(0, 1, 2, 4'hF, 1, 0);
      repeat (3 * FRAME) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL nocommit_model %s", obs());
         end
         if (outpos == 21) begin
            ncmp++;
            if (led !== 7'b0110000) begin nfail++; $display("FAIL nocommit_digit2 got %b want 0110000", led); end
         end
      end
      tick(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 80 && !got; k++) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL nocommit_wait %s", obs());
         end
         if (commit_ack === 1'b1) got = 1;
      end
      ncmp++;
      if (!got) begin nfail++; $display("FAIL nocommit_ack_timeout got none want 1"); end
      repeat (FRAME) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL nocommit_frame %s", obs());
         end
         if (outpos == 21) begin
            ncmp++;
            if ({an, led} !== {4'b1011, 7'b0001110}) begin
               nfail++; $display("FAIL nocommit_F got an=%b led=%b want 1011 0001110", an, led);
            end
         end
      end
   endtask

   task automatic test_boundary_write();
      bit got = 0;
      tick(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 80 && mpos != FRAME - 1; k++) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL bwrite_wait %s", obs());
         end
      end
      tick(0, 1, 1, 4'hA, 1, 0);
      ncmp++;
      if ({commit_ack, pending} !== 2'b10) begin
         nfail++; $display("FAIL bwrite_ack got ack=%b pend=%b want ack=1 pend=0", commit_ack, pending);
      end
      repeat (FRAME) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL bwrite_frame %s", obs());
         end
         if (outpos == 13) begin
            ncmp++;
            if (led !== 7'b0100100) begin nfail++; $display("FAIL bwrite_excluded got %b want 0100100", led); end
         end
      end
      tick(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 80 && !got; k++) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL bwrite_wait2 %s", obs());
         end
         if (commit_ack === 1'b1) got = 1;
      end
      ncmp++;
      if (!got) begin nfail++; $display("FAIL bwrite_ack_timeout got none want 1"); end
      repeat (FRAME) begin
         tick(0, 0, 0, 0, 0, 0);
         if (outpos == 13) begin
            ncmp++;
            if ({an, led} !== {4'b1101, 7'b0001000}) begin
               nfail++; $display("FAIL bwrite_applied got an=%b led=%b want 1101 0001000", an, led);
            end
         end
      end
   endtask

   task automatic test_disable();
      bit got = 0;
      tick(0, 1, 3, 4'h4, 0, 1);
      for (int k = 0; k < 80 && !got; k++) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL disable_wait %s", obs());
         end
         if (commit_ack === 1'b1) got = 1;
      end
      ncmp++;
      if (!got) begin nfail++; $display("FAIL disable_ack_timeout got none want 1"); end
      repeat (FRAME) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL disable_frame %s", obs());
         end
         if (outpos >= 24) begin
            ncmp++;
            if ({an, led} !== {4'hF, 7'h7F}) begin
               nfail++; $display("FAIL disable_slot3 got an=%b led=%h want 1111 7f", an, led);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 80 && mpos != 2 * DIV + 4; k++) tick(0, 0, 0, 0, 0, 0);
      ncmp++;
      if (pending !== 1'b1) begin nfail++; $display("FAIL rstmid_pending_before got %b want 1", pending); end
      tick(1, 0, 0, 0, 0, 0);
      ncmp++;
      if ({led, an, pending, commit_ack} !== {7'h7F, 4'hF, 2'b00}) begin
         nfail++; $display("FAIL rstmid_state %s", obs());
      end
      repeat (70) begin
         tick(0, 0, 0, 0, 0, 0);
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack} ||
             an !== 4'hF || commit_ack !== 1'b0) begin
            nfail++; $display("FAIL rstmid_dark %s", obs());
         end
      end
   endtask

   task automatic test_random();
      repeat (900) begin
         tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0));
         ncmp++;
         if ({led, an, frame_start, pending, commit_ack} !== {e_led, e_an, e_fs, e_pend, e_ack}) begin
            nfail++; $display("FAIL random %s", obs());
         end
      end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_no_commit();
      test_boundary_write();
      test_disable();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
